// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : IF-stage prefetch queue; issues sequential fetches to a 1-cycle
//            instruction memory and buffers {pc, instr} entries for decode.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_rdata,
    output logic                         d_valid,
    output logic [INSTR_WIDTH-1:0]       d_instr,
    output logic [PC_WIDTH-1:0]          d_pc,
    input  logic                         d_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PC_WIDTH-1:0] c_pc_step  = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] c_reset_pc = PC_WIDTH'(RESET_PC);
    localparam logic [CW:0]         c_depth    = (CW+1)'(DEPTH);

    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [CW-1:0]          r_count;
    logic                   r_inflight;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    r_inflight_pc;
    logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];

    logic [CW:0] w_occupied;
    logic        w_push;
    logic        w_pop;

    // Credits: queued entries plus the one possibly in flight never exceed DEPTH.
    assign w_occupied = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign imem_req   = rst_n && !redirect && (w_occupied < c_depth);
    assign imem_addr  = r_fetch_pc;

    assign w_push  = r_inflight && !redirect;
    assign w_pop   = d_valid && d_ready;

    assign count   = r_count;
    assign d_valid = (r_count != '0);
    assign d_pc    = d_valid ? r_pc_mem[r_head]    : '0;
    assign d_instr = d_valid ? r_instr_mem[r_head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_fetch_pc    <= c_reset_pc;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            // Flush wins over everything, including a same-cycle pop.
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_fetch_pc <= redirect_pc;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fetch_pc    <= r_fetch_pc + c_pc_step;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]    <= r_inflight_pc;
            r_instr_mem[r_tail] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed + random stimulus against a queue-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [7:0]  d_pc;
    logic        d_ready;
    logic [2:0]  count;

    fetch_queue #(
        .DEPTH(DEPTH), .PC_WIDTH(8), .INSTR_WIDTH(32), .PC_STEP(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_ready(d_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] words [256];

    // Synchronous instruction memory; garbage on idle cycles exposes stale writes.
    always @(posedge clk) imem_rdata <= imem_req ? words[imem_addr] : $urandom;

    // Reference model: queue of PCs held, optional PC awaiting its memory word.
    logic [7:0] q[$];
    bit         pend_v;
    logic [7:0] pend_pc;
    logic [7:0] fpc;
    int         nchecks;
    int         nerr;
    bit         seen40;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rd, input logic [7:0] rpc, input bit rdy);
        bit e_req;
        bit e_valid;
        redirect    = rd;
        redirect_pc = rpc;
        d_ready     = rdy;
        @(negedge clk);
        e_req   = !rd && ((q.size() + (pend_v ? 1 : 0)) < DEPTH);
        e_valid = (q.size() != 0);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, fpc);
        chk("d_valid", d_valid, e_valid);
        chk("count", count, q.size());
        if (e_valid) begin
            chk("d_pc", d_pc, q[0]);
            chk("d_instr", d_instr, words[q[0]]);
        end
        if (d_valid && d_pc == 8'h40) seen40 = 1'b1;
        @(posedge clk);
        if (rd) begin
            q.delete();
            pend_v = 1'b0;
            fpc    = rpc;
        end else begin
            if (e_valid && rdy) void'(q.pop_front());
            if (pend_v) q.push_back(pend_pc);
            pend_v  = e_req;
            pend_pc = fpc;
            if (e_req) fpc = fpc + 8'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_d_pc", d_pc, 0);
        chk("rst_d_instr", d_instr, 0);
        q.delete();
        pend_v = 1'b0;
        fpc    = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        seen40  = 1'b0;
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        d_ready     = 1'b0;
        pend_v      = 1'b0;
        pend_pc     = 8'h00;
        fpc         = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming with decode always ready
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);

        // Decode stalled from reset: fill, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("full_count", count, 4);
        chk("full_no_req", imem_req, 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);

        // Single pop at full: one refill, count back to 4, tail wraps
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("refill_count", count, 4);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Redirect with three queued and one in flight
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("pre_redirect_count", count, 3);
        cycle(1'b1, 8'h40, 1'b0);
        chk("redirect_d_valid", d_valid, 0);
        chk("redirect_addr", imem_addr, 8'h40);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Back-to-back redirects: only the later target is fetched
        cycle(1'b1, 8'h40, 1'b1);
        cycle(1'b1, 8'h80, 1'b1);
        seen40 = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("no_0x40_after_b2b", seen40, 0);

        // Reset with a request in flight
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Fetch address wraps at 2^PC_WIDTH
        cycle(1'b1, 8'hFC, 1'b1);
        chk("wrap_addr_fc", imem_addr, 8'hFC);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_addr_00", imem_addr, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);

        // Random mix of stalls, redirects and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(($urandom_range(0, 15) == 0), 8'($urandom) & 8'hFC,
                  ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
`default_nettype wire
